// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder interface: decode modes,
// the forward Gray sequence and a transition classifier.
package quad_enc_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // Forward rotation walks {A,B} through 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] FWD_S0 = 2'b00;
  localparam logic [1:0] FWD_S1 = 2'b01;
  localparam logic [1:0] FWD_S2 = 2'b11;
  localparam logic [1:0] FWD_S3 = 2'b10;

  typedef enum logic [1:0] {
    XITION_NONE,
    XITION_FWD,
    XITION_REV,
    XITION_ILLEGAL
  } xition_t;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      FWD_S0:  nxt = FWD_S1;
      FWD_S1:  nxt = FWD_S2;
      FWD_S2:  nxt = FWD_S3;
      default: nxt = FWD_S0;
    endcase
    return nxt;
  endfunction

  function automatic xition_t classify(input logic [1:0] prev, input logic [1:0] cur);
    xition_t x;
    if (prev == cur)                x = XITION_NONE;
    else if (cur == fwd_next(prev)) x = XITION_FWD;
    else if (prev == fwd_next(cur)) x = XITION_REV;
    else                            x = XITION_ILLEGAL;
    return x;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One encoder channel: metastability synchroniser followed by a stability
// filter that only accepts a new level after FILT_LEN consecutive cycles.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int              CNT_W    = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
      // ---- filter stage: synced level must persist before it is accepted
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature decoder with x1/x2/x4 step qualification, a wrapping signed
// position count and a saturating per-window velocity count.
module quad_encoder_counter
  import quad_enc_pkg::*;
#(
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    quad_a,
  input  logic                    quad_b,
  input  logic [1:0]              mode,
  input  logic                    sample,
  input  logic                    pos_clear,
  input  logic                    err_clear,
  output logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    err
);

  localparam int ARM_CYC = SYNC_STAGES + FILT_LEN + 1;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  function automatic logic signed [VEL_W-1:0] vel_sat_add(
    input logic signed [VEL_W-1:0] acc_in,
    input logic signed [1:0]       step_in
  );
    logic signed [VEL_W:0] sum;
    sum = {acc_in[VEL_W-1], acc_in} + (VEL_W+1)'(step_in);
    if (sum[VEL_W] != sum[VEL_W-1]) return sum[VEL_W] ? VEL_MIN : VEL_MAX;
    return sum[VEL_W-1:0];
  endfunction

  logic              a_p0, b_p0;
  logic [1:0]        ab_p0, ab_p1;
  logic [ARM_W-1:0]  arm_cnt;
  logic              armed;
  xition_t           xition;
  logic              a_change, a_rise, qualify, illegal;
  logic signed [1:0] step;
  logic signed [VEL_W-1:0] acc;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .raw(quad_a), .level(a_p0)
  );
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .raw(quad_b), .level(b_p0)
  );

  assign ab_p0 = {a_p0, b_p0};
  assign armed = (arm_cnt == ARM_W'(ARM_CYC));

  // ---- decode stage: previous vs current filtered pair
  always_comb begin
    xition   = classify(ab_p1, ab_p0);
    a_change = ab_p1[1] ^ ab_p0[1];
    a_rise   = ~ab_p1[1] & ab_p0[1];
    case (mode)
      MODE_X1: qualify = a_rise;
      MODE_X2: qualify = a_change;
      default: qualify = 1'b1;
    endcase
    qualify = qualify & armed & ((xition == XITION_FWD) | (xition == XITION_REV));
    illegal = armed & (xition == XITION_ILLEGAL);
    step    = qualify ? ((xition == XITION_FWD) ? 2'sd1 : -2'sd1) : 2'sd0;
  end

  // ---- count stage: position, window accumulator and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt   <= '0;
      ab_p1     <= '0;
      position  <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
      ab_p1 <= ab_p0;

      if (pos_clear) position <= '0;
      else           position <= position + POS_W'(step);

      if (qualify) dir <= (xition == XITION_REV);

      if (illegal)        err <= 1'b1;
      else if (err_clear) err <= 1'b0;

      // A step landing on the strobe cycle closes with the old window
      vel_valid <= sample;
      if (sample) begin
        velocity <= vel_sat_add(acc, step);
        acc      <= '0;
      end else begin
        acc <= vel_sat_add(acc, step);
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench: a default-width instance and a narrow instance (POS_W=8,
// VEL_W=4) share one stimulus stream with hand-computed expectations.
module tb_quad_encoder_counter;
  import quad_enc_pkg::*;

  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic quad_a = 1'b1, quad_b = 1'b1;
  logic [1:0] mode = MODE_X4;
  logic sample = 1'b0, pos_clear = 1'b0, err_clear = 1'b0;

  logic signed [31:0] position;
  logic signed [15:0] velocity;
  logic vel_valid, dir, err;
  logic signed [7:0] position_s;
  logic signed [3:0] velocity_s;
  logic vel_valid_s, dir_s, err_s;

  int checks = 0;
  int errors = 0;

  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int idx = 2;

  always #5 clk = ~clk;

  quad_encoder_counter dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .mode(mode),
    .sample(sample), .pos_clear(pos_clear), .err_clear(err_clear),
    .position(position), .velocity(velocity), .vel_valid(vel_valid),
    .dir(dir), .err(err)
  );

  quad_encoder_counter #(.POS_W(8), .VEL_W(4)) dut_s (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .mode(mode),
    .sample(sample), .pos_clear(pos_clear), .err_clear(err_clear),
    .position(position_s), .velocity(velocity_s), .vel_valid(vel_valid_s),
    .dir(dir_s), .err(err_s)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input bit fwd);
    idx = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
    {quad_a, quad_b} = seq[idx];
  endtask

  task automatic steps(input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      move(fwd);
      cyc(HOLD);
    end
  endtask

  task automatic strobe();
    sample = 1'b1;
    cyc(1);
    sample = 1'b0;
  endtask

  initial begin
    // reset with A=B=1 held
    cyc(2);
    chk("rst_position", position, 0);
    chk("rst_velocity", velocity, 0);
    chk("rst_vel_valid", vel_valid, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    cyc(20);
    chk("armed_err", err, 0);
    chk("armed_position", position, 0);

    strobe();
    chk("empty_window_vel", velocity, 0);
    chk("empty_window_valid", vel_valid, 1);

    // x4 forward, 40 transitions
    steps(40, 1'b1);
    strobe();
    chk("x4_fwd_position", position, 40);
    chk("x4_fwd_velocity", velocity, 40);
    chk("x4_fwd_vel_sat", velocity_s, 7);
    chk("x4_fwd_dir", dir, 0);
    chk("x4_fwd_valid_hi", vel_valid, 1);
    cyc(1);
    chk("x4_fwd_valid_lo", vel_valid, 0);

    // reverse in x1 then x2
    mode = MODE_X1;
    steps(40, 1'b0);
    chk("x1_rev_position", position, 30);
    chk("x1_rev_dir", dir, 1);
    mode = MODE_X2;
    steps(40, 1'b0);
    chk("x2_rev_position", position, 10);
    chk("x2_rev_pos_narrow", position_s, 10);
    strobe();
    chk("rev_velocity", velocity, -30);
    chk("rev_vel_sat", velocity_s, -8);

    // 2-cycle glitch on A is filtered out
    mode = MODE_X4;
    quad_a = ~quad_a;
    cyc(2);
    quad_a = ~quad_a;
    cyc(HOLD);
    chk("glitch_position", position, 10);
    chk("glitch_err", err, 0);

    // both channels toggle together: illegal
    quad_a = ~quad_a;
    quad_b = ~quad_b;
    idx = (idx + 2) % 4;
    cyc(HOLD);
    chk("illegal_err", err, 1);
    chk("illegal_position", position, 10);
    chk("illegal_dir", dir, 1);
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("err_clear", err, 0);

    // pos_clear on the same cycle as a step: the step is discarded
    move(1'b1);
    cyc(6);
    chk("preclear_position", position, 10);
    pos_clear = 1'b1;
    cyc(1);
    pos_clear = 1'b0;
    chk("clear_vs_step", position, 0);
    cyc(HOLD);
    chk("clear_vs_step_hold", position, 0);

    // flush window (holds the discarded-from-position step), then sample + step
    strobe();
    chk("flush_velocity", velocity, 1);
    move(1'b1);
    cyc(6);
    sample = 1'b1;
    cyc(1);
    chk("sample_with_step_vel", velocity, 1);
    chk("sample_with_step_valid", vel_valid, 1);
    cyc(1);
    sample = 1'b0;
    chk("next_window_vel", velocity, 0);
    chk("next_window_valid", vel_valid, 1);
    cyc(1);
    chk("next_window_valid_lo", vel_valid, 0);
    chk("sample_step_position", position, 1);
    cyc(HOLD);

    // 20 steps in one window saturate the narrow velocity
    steps(20, 1'b1);
    strobe();
    chk("w20_velocity", velocity, 20);
    chk("w20_vel_sat", velocity_s, 7);
    chk("w20_position", position, 21);

    // narrow position wraps 127 -> -128
    pos_clear = 1'b1;
    cyc(1);
    pos_clear = 1'b0;
    chk("pos_clear", position, 0);
    steps(127, 1'b1);
    chk("wrap_pre_narrow", position_s, 127);
    chk("wrap_pre_wide", position, 127);
    steps(1, 1'b1);
    chk("wrap_narrow", position_s, -128);
    chk("wrap_wide", position, 128);
    chk("wrap_dir", dir, 0);

    // asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    chk("midrst_position", position, 0);
    chk("midrst_pos_narrow", position_s, 0);
    chk("midrst_velocity", velocity, 0);
    cyc(1);
    rst = 1'b0;
    cyc(20);
    chk("rearm_err", err, 0);
    chk("rearm_position", position, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_counter.md
# quad_encoder_counter

Parametrised quadrature-encoder interface for the robot's motor feedback path. Synchronises and glitch-filters the A/B channels, then decodes them in x1/x2/x4 mode. Keeps a signed wrapping position count and a signed per-window velocity count, captured on an external sample strobe. The strobe comes from the control-loop timebase, and the velocity result feeds the speed PID.

## Interface
- `POS_W`, 32: width of signed position counter.
- `VEL_W`, 16: width of signed window (velocity) count.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `FILT_LEN`, 4: consecutive stable cycles required to accept a new channel level, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous and active-high, clears all state.
- `quad_a`, `quad_b` in 1 each: raw encoder channels, asynchronous to `clk`.
- `mode` in 2: 0 = x1, 1 = x2, 2 or 3 = x4.
- `sample` in 1: one-cycle strobe closing the current velocity window.
- `pos_clear` in 1: synchronous clear of position.
- `err_clear` in 1: clears sticky error.
- `position` out POS_W: signed position, two's complement.
- `velocity` out VEL_W: signed count of the last closed window.
- `vel_valid` out 1: one-cycle pulse when `velocity` updates.
- `dir` out 1: direction of the last accepted step; 0 = forward, 1 = reverse.
- `err` out 1: sticky illegal-transition flag.

## Operation
- Per channel: SYNC_STAGES flop chain, then a stability filter.
  - Filter counter increments while the synced level differs from the filtered level.
  - When the counter equals FILT_LEN-1 and the levels still differ, the filtered level takes the synced value and the counter clears.
  - Any cycle with synced equal to filtered clears the counter.
- Decoder compares the previous and current filtered pair {A,B}.
  - Forward sequence: 00→01→11→10→00. The reverse of that sequence is reverse direction.
  - Both bits changing in one cycle is illegal: set `err`, no count, `dir` unchanged.
- Step qualification by mode:
  - x4: every legal transition steps ±1.
  - x2: only transitions where A changes step.
  - x1: only A rising steps.
  - Sign comes from the decoded direction. `dir` updates only on qualified steps.
- Position: `position` += step, wrapping modulo 2^POS_W.
  - `pos_clear` forces 0 and wins over a same-cycle step, i.e. that step is discarded.
- Velocity window accumulator adds step each cycle, saturating at −2^(VEL_W−1) / 2^(VEL_W−1)−1.
  - On `sample`: `velocity` ← accumulator + that cycle's step (saturated), `vel_valid` = 1 next cycle, accumulator ← 0.
  - A step coinciding with `sample` belongs to the closing window.
- `mode` change takes effect on the next decoded transition. No state is flushed.
- Arming: after `rst` deasserts, the decoder is unarmed for SYNC_STAGES+FILT_LEN+1 cycles.
  - While unarmed, the previous-state register tracks the filtered pair.
  - No steps and no errors occur while unarmed, so a static input pattern at power-up does not flag an error.
- `err_clear` clears `err`; a same-cycle illegal transition wins (`err` stays 1).

## Timing
- All outputs registered.
- Reset values: `position` 0, `velocity` 0, `vel_valid` 0, `dir` 0, `err` 0. Sync/filter state 0, unarmed.
- Latency: an input level change first sampled at edge k appears on the synchroniser output at edge k+SYNC_STAGES-1, on the filtered level at k+SYNC_STAGES-1+FILT_LEN, and on `position` one edge later.
- `sample` asserted at edge n: `velocity` and `vel_valid` are valid after edge n. No backpressure; consumers must take it that cycle.
- Back-to-back `sample` strobes are legal. A window with no steps reports 0.
- Max countable rate: one filtered transition per FILT_LEN cycles per channel. Faster pulses are filtered out, not counted.
- `rst` asserted mid-operation clears everything immediately and re-arms.

## Structure
- Shared package `quad_enc_pkg`: `MODE_X1` = 2'd0, `MODE_X2` = 2'd1, `MODE_X4` = 2'd2, and forward-sequence encoding constants.
- Sub-module `quad_input_filter` (parameters SYNC_STAGES, FILT_LEN): synchroniser plus stability filter for one channel, instantiated for A and B.
- Top holds the arming counter, decoder, position and window accumulators.

## Test plan
- Reset with A=B=1 held: after arming, `err`=0 and `position`=0.
- x4, FILT_LEN=4, 10 forward cycles (40 transitions, each level held ≥8 clk), then `sample` → `position`=40, `velocity`=40, `dir`=0, `vel_valid` high for exactly 1 cycle.
- Same 10 cycles reversed in x1, then in x2 → `position` decreases by 10 in x1 and by 20 in x2; `dir`=1.
- 2-cycle glitch on A with FILT_LEN=4 → no count. Simultaneous A and B toggle held stable → `err`=1, position unchanged; `err_clear` → 0.
- POS_W=8 at `position`=127, one forward step → −128. VEL_W=4 with 20 forward steps in one window → `velocity`=7.
- `pos_clear` and a step in the same cycle → `position`=0. `sample` and a step in the same cycle → step appears in the captured `velocity`, next window starts at 0.
